// File: rtl/if_id_buffer_pkg.sv
// Shared definitions for the fetch-to-decode buffer.
//   NopInstr      : addi x0,x0,0, presented to decode whenever the buffer is empty
//   PcResetVector : reset vector used by the fetch stage and by benches
//   occ_e         : occupancy classification derived from the entry count
package if_id_buffer_pkg;

    localparam logic [31:0] NopInstr      = 32'h0000_0013;
    localparam logic [31:0] PcResetVector = 32'h3000_0000;

    typedef enum logic [1:0] {
        OccEmpty,
        OccPartial,
        OccFull
    } occ_e;

    // Occupancy is a pure function of the count; there is no separate state register.
    function automatic occ_e occupancy(input int unsigned count, input int unsigned depth);
        if (count == 0) begin
            return OccEmpty;
        end else if (count >= depth) begin
            return OccFull;
        end
        return OccPartial;
    endfunction

endpackage

// File: rtl/if_id_buffer_sync_fifo_ctrl.sv
// Pointer and count control for a small circular FIFO.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   flush_i       : clear pointers and count at the next edge, block push/pop this cycle
//   push_req_i    : producer offers an entry
//   pop_req_i     : consumer takes the head entry
//   push_o        : an entry is written this cycle (at wr_ptr_o)
//   wr_ptr_o      : write pointer
//   rd_ptr_o      : read pointer (head entry)
//   count_o       : number of occupied entries
//   full_o        : count == DEPTH
//   empty_o       : count == 0
module if_id_buffer_sync_fifo_ctrl
    import if_id_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            push_req_i,
    input  logic            pop_req_i,
    output logic            push_o,
    output logic [PtrW-1:0] wr_ptr_o,
    output logic [PtrW-1:0] rd_ptr_o,
    output logic [CntW-1:0] count_o,
    output logic            full_o,
    output logic            empty_o
);

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            pop;
    occ_e            occ;

    assign occ     = occupancy(32'(count_q), DEPTH);
    assign full_o  = (occ == OccFull);
    assign empty_o = (occ == OccEmpty);

    // Full refuses a push even if a pop happens in the same cycle.
    assign push_o = push_req_i && !full_o && !flush_i;
    assign pop    = pop_req_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so natural overflow gives the modulo wrap.
            if (push_o) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)    rd_ptr_d = rd_ptr_q + PtrW'(1);
            unique case ({push_o, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_ptr_o = wr_ptr_q;
    assign rd_ptr_o = rd_ptr_q;
    assign count_o  = count_q;

endmodule

// File: rtl/if_id_buffer.sv
// Fetch-to-decode decoupling buffer: a small circular FIFO of {pc, instr, misaligned}.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   flush_i           : redirect; drops buffered and incoming entries, hides the head
//   in_valid_i        : fetch presents in_pc_i / in_instr_i
//   in_ready_o        : buffer not full (registered state only)
//   in_pc_i           : fetch address
//   in_instr_i        : fetched instruction word (not inspected)
//   out_valid_o       : head entry available to decode
//   out_ready_i       : decode consumes the head entry
//   out_pc_o          : head pc (0 when empty)
//   out_instr_o       : head instruction (NOP_INSTR when empty)
//   out_misaligned_o  : head pc[1:0] != 0 (0 when empty)
//   count_o           : number of occupied entries
module if_id_buffer
    import if_id_buffer_pkg::*;
#(
    parameter int unsigned     DEPTH     = 2,
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(NopInstr),
    localparam int unsigned    PtrW      = $clog2(DEPTH),
    localparam int unsigned    CntW      = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [XLEN-1:0] in_pc_i,
    input  logic [XLEN-1:0] in_instr_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_pc_o,
    output logic [XLEN-1:0] out_instr_o,
    output logic            out_misaligned_o,
    output logic [CntW-1:0] count_o
);

    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic            push;
    logic            full;
    logic            empty;

    // Data array is not reset; only the pointers and count are.
    logic [XLEN-1:0] pc_q    [DEPTH];
    logic [XLEN-1:0] instr_q [DEPTH];
    logic            mis_q   [DEPTH];

    if_id_buffer_sync_fifo_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush_i),
        .push_req_i (in_valid_i),
        .pop_req_i  (out_ready_i),
        .push_o     (push),
        .wr_ptr_o   (wr_ptr),
        .rd_ptr_o   (rd_ptr),
        .count_o    (count_o),
        .full_o     (full),
        .empty_o    (empty)
    );

    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_ptr]    <= in_pc_i;
            instr_q[wr_ptr] <= in_instr_i;
            mis_q[wr_ptr]   <= |in_pc_i[1:0];
        end
    end

    assign in_ready_o = !full;
    // Hide the head during a flush so decode cannot consume a stale entry.
    assign out_valid_o = !empty && !flush_i;

    always_comb begin
        out_pc_o         = '0;
        out_instr_o      = NOP_INSTR;
        out_misaligned_o = 1'b0;
        if (!empty) begin
            out_pc_o         = pc_q[rd_ptr];
            out_instr_o      = instr_q[rd_ptr];
            out_misaligned_o = mis_q[rd_ptr];
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
module tb_if_id_buffer;
    import if_id_buffer_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] B     = PcResetVector;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;
    logic            out_misaligned;
    logic [CW-1:0]   count;

    if_id_buffer #(
        .DEPTH     (DEPTH),
        .XLEN      (XLEN),
        .NOP_INSTR (NOP)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .flush_i          (flush),
        .in_valid_i       (in_valid),
        .in_ready_o       (in_ready),
        .in_pc_i          (in_pc),
        .in_instr_i       (in_instr),
        .out_valid_o      (out_valid),
        .out_ready_i      (out_ready),
        .out_pc_o         (out_pc),
        .out_instr_o      (out_instr),
        .out_misaligned_o (out_misaligned),
        .count_o          (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          chk;
        logic          rst;
        logic          flush;
        logic          in_valid;
        logic          out_ready;
        logic [31:0]   pc;
        logic [31:0]   instr;
        logic          exp_out_valid;
        logic          exp_in_ready;
        logic [CW-1:0] exp_count;
        logic [31:0]   exp_pc;
        logic          exp_mis;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
    } entry_t;

    vec_t   vecs[$];
    entry_t sb[$];
    int     n_checks = 0;
    int     n_fail   = 0;

    function automatic logic [31:0] mk_instr(input logic [31:0] pc);
        return {pc[15:0], 16'h0513};
    endfunction

    function automatic void add(input logic chk, input logic r, input logic fl,
                                input logic iv, input logic ordy,
                                input logic [31:0] pc, input logic [31:0] instr,
                                input logic eov, input logic eir, input int ecnt,
                                input logic [31:0] epc, input logic emis);
        vec_t v;
        v.chk           = chk;
        v.rst           = r;
        v.flush         = fl;
        v.in_valid      = iv;
        v.out_ready     = ordy;
        v.pc            = pc;
        v.instr         = instr;
        v.exp_out_valid = eov;
        v.exp_in_ready  = eir;
        v.exp_count     = CW'(ecnt);
        v.exp_pc        = epc;
        v.exp_mis       = emis;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        logic   m_push;
        logic   m_pop;
        entry_t e;
        rst       = v.rst;
        flush     = v.flush;
        in_valid  = v.in_valid;
        out_ready = v.out_ready;
        in_pc     = v.pc;
        in_instr  = v.instr;
        @(negedge clk);
        if (v.chk) begin
            // Hand-derived expectations from the vector table.
            check($sformatf("v%0d out_valid", idx), 32'(out_valid), 32'(v.exp_out_valid));
            check($sformatf("v%0d in_ready", idx), 32'(in_ready), 32'(v.exp_in_ready));
            check($sformatf("v%0d count", idx), 32'(count), 32'(v.exp_count));
            check($sformatf("v%0d out_pc", idx), out_pc, v.exp_pc);
            check($sformatf("v%0d out_mis", idx), 32'(out_misaligned), 32'(v.exp_mis));
            // Scoreboard model of the FIFO contents.
            check($sformatf("v%0d sb_count", idx), 32'(count), sb.size());
            if (sb.size() != 0) begin
                check($sformatf("v%0d sb_pc", idx), out_pc, sb[0].pc);
                check($sformatf("v%0d sb_instr", idx), out_instr, sb[0].instr);
                check($sformatf("v%0d sb_mis", idx), 32'(out_misaligned), 32'(sb[0].mis));
            end else begin
                check($sformatf("v%0d empty_instr", idx), out_instr, NOP);
            end
        end
        m_push = v.in_valid && (sb.size() < DEPTH) && !v.flush;
        m_pop  = v.out_ready && (sb.size() != 0) && !v.flush;
        @(posedge clk);
        if (v.rst || v.flush) begin
            sb.delete();
        end else begin
            if (m_pop) void'(sb.pop_front());
            if (m_push) begin
                e.pc    = v.pc;
                e.instr = v.instr;
                e.mis   = |v.pc[1:0];
                sb.push_back(e);
            end
        end
        #1;
    endtask

    initial begin
        logic [31:0] w;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_pc     = '0;
        in_instr  = '0;

        // Reset then idle.
        add(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        // Streaming with out_ready=1; one all-zero instruction word is buffered as-is.
        add(1, 0, 0, 1, 1, B,      mk_instr(B),     0, 1, 0, 0,      0);
        add(1, 0, 0, 1, 1, B + 4,  mk_instr(B + 4), 1, 1, 1, B,      0);
        add(1, 0, 0, 1, 1, B + 8,  32'h0,           1, 1, 1, B + 4,  0);
        add(1, 0, 0, 0, 1, 0,      0,               1, 1, 1, B + 8,  0);
        add(1, 0, 0, 0, 1, 0,      0,               0, 1, 0, 0,      0);
        // Back-pressure to full; third push refused, then drain.
        add(1, 0, 0, 1, 0, B,      mk_instr(B),     0, 1, 0, 0,      0);
        add(1, 0, 0, 1, 0, B + 4,  mk_instr(B + 4), 1, 1, 1, B,      0);
        add(1, 0, 0, 1, 0, B + 8,  mk_instr(B + 8), 1, 0, 2, B,      0);
        add(1, 0, 0, 1, 1, B + 8,  mk_instr(B + 8), 1, 0, 2, B,      0);
        add(1, 0, 0, 0, 1, 0,      0,               1, 1, 1, B + 4,  0);
        add(1, 0, 0, 0, 0, 0,      0,               0, 1, 0, 0,      0);
        // Wrap-around: five simultaneous push/pop pairs at count=1.
        w = B + 32'h100;
        add(1, 0, 0, 1, 0, w, mk_instr(w), 0, 1, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            add(1, 0, 0, 1, 1, w + 32'(4 * (k + 1)), mk_instr(w + 32'(4 * (k + 1))),
                1, 1, 1, w + 32'(4 * k), 0);
        end
        add(1, 0, 0, 0, 1, 0, 0, 1, 1, 1, w + 32'd20, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,          0);
        // Flush mid-stream with a concurrent push and pop request.
        add(1, 0, 0, 1, 0, B,      mk_instr(B),      0, 1, 0, 0, 0);
        add(1, 0, 0, 1, 0, B + 4,  mk_instr(B + 4),  1, 1, 1, B, 0);
        add(1, 0, 1, 1, 1, B + 16, mk_instr(B + 16), 0, 0, 2, B, 0);
        add(1, 0, 0, 0, 1, 0,      0,                0, 1, 0, 0, 0);
        add(1, 0, 0, 0, 1, 0,      0,                0, 1, 0, 0, 0);
        // Misaligned pc flagged; reset wins over a concurrent push.
        add(1, 0, 0, 1, 0, B + 2, mk_instr(B + 2), 0, 1, 0, 0,     0);
        add(1, 1, 0, 1, 0, B + 8, mk_instr(B + 8), 1, 1, 1, B + 2, 1);
        add(1, 0, 0, 0, 0, 0,     0,               0, 1, 0, 0,     0);
        add(1, 0, 0, 0, 1, 0,     0,               0, 1, 0, 0,     0);

        foreach (vecs[i]) apply(vecs[i], i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
